// File: rtl/ie_idver_serializer_pkg.sv
// Shared types and constants for the ICE ID/version serial readout.
// IE_IDVER_PARITY_EN appends an even-parity bit, making the frame 33 bits long.
package ie_idver_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

   localparam int IDVER_WIDTH = 32;
   localparam logic [IDVER_WIDTH-1:0] IDVER_UNSET = 32'h9999_9999;

`ifdef IE_IDVER_PARITY_EN
   localparam int NBITS = 33;
`else
   localparam int NBITS = 32;
`endif

   localparam int IDX_W = $clog2(NBITS);

endpackage

// File: rtl/ie_idver_serializer_if.sv
// Host-side bundle of the ID/version serializer: request/abort in, serial frame out.
// The slave modport is the serializer's view; master is the host's view.
interface ie_idver_serializer_if;
   import ie_idver_pkg::*;

   logic [IDVER_WIDTH-1:0] IDVER;
   logic                   RDREQ;
   logic                   ABORT;
   logic                   IDSDO;
   logic                   IDSVLD;
   logic                   IDSTB;
   logic                   IDBUSY;
   logic                   IDDONE;
   logic                   IDUNSET;

   modport master (
      output IDVER, RDREQ, ABORT,
      input  IDSDO, IDSVLD, IDSTB, IDBUSY, IDDONE, IDUNSET
   );

   modport slave (
      input  IDVER, RDREQ, ABORT,
      output IDSDO, IDSVLD, IDSTB, IDBUSY, IDDONE, IDUNSET
   );

endinterface

// File: rtl/ie_idver_serializer_bitdiv.sv
// Bit-period counter: strobe is a registered flag that is high in the last
// cycle of every DIV-cycle period while enabled.
module ie_bitdiv #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic strobe
);

   localparam logic [7:0] TOP = 8'(DIV - 1);

   logic [7:0] cnt_q;

   // Counter idles at zero so a dropped enable also drops the strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         strobe <= 1'b0;
      end else if (load || (enable && cnt_q == 8'd0)) begin
         cnt_q  <= TOP;
         strobe <= (TOP == 8'd0);
      end else if (enable) begin
         cnt_q  <= cnt_q - 8'd1;
         strobe <= (cnt_q == 8'd1);
      end else begin
         cnt_q  <= '0;
         strobe <= 1'b0;
      end
   end

endmodule

// File: rtl/ie_idver_serializer.sv
// Snapshots the ICE ID/version word on a RDREQ rising edge and shifts it out
// MSB-first at DIV cycles per bit. IE_IDVER_PARITY_EN adds a trailing even-parity bit.
module ie_idver_serializer
   import ie_idver_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic                 CLK,
   input  logic                 RESET,
   ie_idver_serializer_if.slave bus
);

   state_e                 state_q, state_d;
   logic                   rdreq_d;
   logic [IDVER_WIDTH-1:0] shadow_q;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   strobe;
   logic                   rdreq_rise;
   logic                   last_bit;
   logic                   div_load;
   logic                   div_en;
   logic                   sdo_d;
   logic                   sdo_q, svld_q, busy_q, done_q, unset_q;

   // Bit index counts down to 0; with parity, index 0 is the parity slot
   function automatic logic data_bit(input logic [IDVER_WIDTH-1:0] w,
                                     input logic [IDX_W-1:0] i);
`ifdef IE_IDVER_PARITY_EN
      return (i == '0) ? ^w : w[5'(i - IDX_W'(1))];
`else
      return w[i];
`endif
   endfunction

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      rdreq_rise = bus.RDREQ & ~rdreq_d;
      last_bit   = strobe && (idx_q == '0);
      state_d    = state_q;
      idx_d      = idx_q;
      sdo_d      = 1'b0;

      if (bus.ABORT) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (rdreq_rise) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // Output bit is prepared one edge ahead so IDSDO comes straight from a flop
      if (state_d == SHIFT) begin
         if (state_q == LOAD) begin
            sdo_d = bus.IDVER[IDVER_WIDTH-1];
            idx_d = IDX_W'(NBITS - 1);
         end else if (strobe) begin
            sdo_d = data_bit(shadow_q, idx_q - IDX_W'(1));
            idx_d = idx_q - IDX_W'(1);
         end else begin
            sdo_d = sdo_q;
         end
      end
   end

   assign div_load = (state_q == LOAD) && !bus.ABORT;
   assign div_en   = (state_q == SHIFT) && (state_d == SHIFT);

   ie_bitdiv #(.DIV(DIV)) u_bitdiv (
      .clk    (CLK),
      .rst    (RESET),
      .load   (div_load),
      .enable (div_en),
      .strobe (strobe)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rdreq_d  <= 1'b0;
         shadow_q <= '0;
         idx_q    <= '0;
         sdo_q    <= 1'b0;
         svld_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         unset_q  <= 1'b0;
      end else begin
         rdreq_d <= bus.RDREQ;
         idx_q   <= idx_d;
         sdo_q   <= sdo_d;
         svld_q  <= (state_d == SHIFT);
         busy_q  <= (state_d == LOAD) || (state_d == SHIFT);
         done_q  <= (state_d == DONE);
         // An aborted LOAD leaves the previous snapshot and flag untouched
         if (div_load) begin
            shadow_q <= bus.IDVER;
            unset_q  <= (bus.IDVER == IDVER_UNSET);
         end
      end
   end

   assign bus.IDSDO   = sdo_q;
   assign bus.IDSVLD  = svld_q;
   assign bus.IDSTB   = strobe;
   assign bus.IDBUSY  = busy_q;
   assign bus.IDDONE  = done_q;
   assign bus.IDUNSET = unset_q;

endmodule

// File: tb/tb_ie_idver_serializer.sv
// Directed bench for ie_idver_serializer: a DIV=4 and a DIV=1 instance share
// clock and reset; every expectation comes from the frame timing formulas.
module tb_ie_idver_serializer;
   import ie_idver_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ie_idver_serializer_if bus4();
   ie_idver_serializer_if bus1();

   ie_idver_serializer #(.DIV(4)) dut4 (.CLK(clk), .RESET(rst), .bus(bus4));
   ie_idver_serializer #(.DIV(1)) dut1 (.CLK(clk), .RESET(rst), .bus(bus1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int cyc,
                      input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs4();
      return {27'd0, bus4.IDSDO, bus4.IDSVLD, bus4.IDSTB, bus4.IDBUSY, bus4.IDDONE};
   endfunction

   function automatic logic [31:0] obs1();
      return {27'd0, bus1.IDSDO, bus1.IDSVLD, bus1.IDSTB, bus1.IDBUSY, bus1.IDDONE};
   endfunction

   // Bit k of the frame, k = 0 is IDVER[31]; k = 32 is the parity bit
   function automatic logic exp_bit(input logic [31:0] w, input int k);
      if (k < 32) return w[31-k];
      return ^w;
   endfunction

   // {IDSDO, IDSVLD, IDSTB, IDBUSY, IDDONE} at cycle c after a RDREQ rise at cycle 0
   function automatic logic [31:0] model(input logic [31:0] w, input int div, input int c);
      logic v, b, s;
      int   k, ph;
      b  = (c >= 1) && (c <= 1 + NBITS*div);
      v  = (c >= 2) && (c <= 1 + NBITS*div);
      k  = v ? (c - 2) / div : 0;
      ph = v ? (c - 2) % div : 0;
      s  = v && (ph == div - 1);
      return {27'd0, v ? exp_bit(w, k) : 1'b0, v, s, b, (c == 2 + NBITS*div)};
   endfunction

   task automatic xfer4(input logic [31:0] w, input logic unset_prev, input string tag);
      logic u;
      bus4.RDREQ = 1'b0;
      tick();
      bus4.IDVER = w;
      bus4.RDREQ = 1'b1;
      for (int c = 1; c <= 4 + NBITS*4; c++) begin
         tick();
         if (c == 10) bus4.IDVER = ~w;
         chk(tag, c, obs4(), model(w, 4, c));
         u = (c >= 2) ? (w == IDVER_UNSET) : unset_prev;
         chk({tag, "_unset"}, c, {31'd0, bus4.IDUNSET}, {31'd0, u});
      end
   endtask

   initial begin
      bus4.IDVER = '0; bus4.RDREQ = 1'b0; bus4.ABORT = 1'b0;
      bus1.IDVER = '0; bus1.RDREQ = 1'b0; bus1.ABORT = 1'b0;

      tick();
      tick();
      chk("rst_out4",   0, obs4(), 32'd0);
      chk("rst_out1",   0, obs1(), 32'd0);
      chk("rst_unset4", 0, {31'd0, bus4.IDUNSET}, 32'd0);
      rst = 1'b0;
      tick();

      xfer4(32'hA5C3_0F01, 1'b0, "divA");
      xfer4(32'h9999_9999, 1'b0, "unset");
      xfer4(32'h0102_0304, 1'b1, "clear");

      // ABORT mid-transfer with RDREQ held high
      bus4.RDREQ = 1'b0;
      tick();
      bus4.IDVER = 32'hA5C3_0F01;
      bus4.RDREQ = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         chk("abort_pre", c, obs4(), model(32'hA5C3_0F01, 4, c));
      end
      bus4.ABORT = 1'b1;
      tick();
      chk("abort_idle", 41, obs4(), 32'd0);
      bus4.ABORT = 1'b0;
      for (int c = 42; c <= 50; c++) begin
         tick();
         chk("abort_hold", c, obs4(), 32'd0);
      end
      bus4.RDREQ = 1'b0;
      tick();
      bus4.RDREQ = 1'b1;
      tick();
      chk("abort_restart_busy", 1, {31'd0, bus4.IDBUSY}, 32'd1);
      tick();
      chk("abort_restart_bit", 2, {30'd0, bus4.IDSDO, bus4.IDSVLD}, 32'd3);
      bus4.ABORT = 1'b1;
      tick();
      bus4.ABORT = 1'b0;

      // ABORT coinciding with a RDREQ edge consumes that edge
      bus4.RDREQ = 1'b0;
      tick();
      bus4.RDREQ = 1'b1;
      bus4.ABORT = 1'b1;
      tick();
      chk("abort_edge", 1, obs4(), 32'd0);
      bus4.ABORT = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         tick();
         chk("abort_consumed", c, obs4(), 32'd0);
      end
      bus4.RDREQ = 1'b0;

      // DIV = 1: one cycle per bit, strobe on every data cycle
      tick();
      bus1.IDVER = 32'hFFFF_0000;
      bus1.RDREQ = 1'b1;
      for (int c = 1; c <= NBITS + 4; c++) begin
         tick();
         chk("div1", c, obs1(), model(32'hFFFF_0000, 1, c));
      end
      bus1.RDREQ = 1'b0;

      // Asynchronous reset in the middle of a transfer
      tick();
      bus4.IDVER = 32'h9999_9999;
      bus4.RDREQ = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         chk("rst_pre", c, obs4(), model(32'h9999_9999, 4, c));
      end
      #2;
      rst = 1'b1;
      bus4.RDREQ = 1'b0;
      #1;
      chk("rst_mid_out",   20, obs4(), 32'd0);
      chk("rst_mid_unset", 20, {31'd0, bus4.IDUNSET}, 32'd0);
      chk("rst_mid_state", 20, {30'd0, dut4.state_q}, {30'd0, IDLE});
      #1;
      rst = 1'b0;
      tick();
      xfer4(32'h3C5A_96E1, 1'b0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
